// File: rtl/ir_pkg.sv
// Shared types, widths and helpers for the IR sensing sequencer.
package ir_pkg;

   localparam int unsigned RES_W  = 12;
   localparam int unsigned CHNL_W = 3;
   localparam int unsigned DTRM_W = 9;

   localparam logic [CHNL_W-1:0] LFT_CHNL  = 3'd0;
   localparam logic [CHNL_W-1:0] RGHT_CHNL = 3'd4;

   typedef enum logic [2:0] {IDLE, SETTLE, CNV_L, CNV_R, UPDT, WAIT} ir_seq_state_t;

   // Clamp a 14b signed delta into the 9b signed derivative range.
   function automatic logic signed [DTRM_W-1:0] sat9(input logic signed [13:0] d);
      if (d > 14'sd255)
         return 9'sd255;
      else if (d < -14'sd256)
         return -9'sd256;
      else
         return d[DTRM_W-1:0];
   endfunction

endpackage

// File: rtl/ir_smpl_seq_if.sv
// A2D request/response handshake between the IR sequencer and the shared converter.
interface ir_smpl_seq_if;
   import ir_pkg::*;

   logic              a2d_strt;
   logic [CHNL_W-1:0] a2d_chnl;
   logic              a2d_cnv_cmplt;
   logic [RES_W-1:0]  a2d_res;

   modport master (output a2d_strt, a2d_chnl, input a2d_cnv_cmplt, a2d_res);
   modport slave  (input a2d_strt, a2d_chnl, output a2d_cnv_cmplt, a2d_res);

endinterface

// File: rtl/ir_dtrm_calc.sv
// Open-side detection and saturated derivative of the left/right difference.
// IR_AVG_EN halves the delta before saturation.
module ir_dtrm_calc
   import ir_pkg::*;
#(
   parameter logic [RES_W-1:0] OPN_THRESH = 12'h300
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [RES_W-1:0]         lft,
   input  logic [RES_W-1:0]         rght,
   input  logic                     upd,
   input  logic                     clr,
   output logic                     lft_opn_c,
   output logic                     rght_opn_c,
   output logic signed [DTRM_W-1:0] dtrm_c
);

   logic signed [RES_W:0]   diff;
   logic signed [RES_W:0]   prev_diff;
   logic signed [RES_W+1:0] delta;
   logic signed [RES_W+1:0] delta_s;
   logic                    prev_vld;

   always_comb begin
      lft_opn_c  = (lft < OPN_THRESH);
      rght_opn_c = (rght < OPN_THRESH);
      diff       = $signed({1'b0, lft}) - $signed({1'b0, rght});
      delta      = 14'(diff) - 14'(prev_diff);
`ifdef IR_AVG_EN
      delta_s    = delta >>> 1;
`else
      delta_s    = delta;
`endif
      dtrm_c     = '0;
      if (prev_vld && !lft_opn_c && !rght_opn_c)
         dtrm_c = sat9(delta_s);
   end

   // History only counts as valid when the sample it came from had both sides closed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_diff <= '0;
         prev_vld  <= 1'b0;
      end else if (clr) begin
         prev_vld  <= 1'b0;
      end else if (upd) begin
         prev_diff <= diff;
         prev_vld  <= ~(lft_opn_c | rght_opn_c);
      end
   end

endmodule

// File: rtl/ir_smpl_seq.sv
// IR emitter / A2D sequencer: settle, convert left then right, publish sample with derivative term.
// Build option IR_AVG_EN: two back-to-back conversions per side, averaged.
module ir_smpl_seq
   import ir_pkg::*;
#(
   parameter int unsigned      SETTLE_CLKS = 1024,
   parameter int unsigned      PERIOD_CLKS = 65536,
   parameter int unsigned      TMO_CLKS    = 4096,
   parameter logic [RES_W-1:0] OPN_THRESH  = 12'h300
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   ir_smpl_seq_if.master            a2d,
   output logic                     IR_en,
   output logic [RES_W-1:0]         lft_IR,
   output logic [RES_W-1:0]         rght_IR,
   output logic                     lft_opn,
   output logic                     rght_opn,
   output logic signed [DTRM_W-1:0] IR_Dtrm,
   output logic                     smpl_vld,
   output logic                     a2d_err
);

   localparam int unsigned SET_W = $clog2(SETTLE_CLKS + 1);
   localparam int unsigned PER_W = $clog2(PERIOD_CLKS + 1);
   localparam int unsigned TMO_W = $clog2(TMO_CLKS + 1);
   localparam int unsigned SUM_W = RES_W + 1;

   ir_seq_state_t state, nxt_state;

   logic [SET_W-1:0] set_cnt;
   logic [PER_W-1:0] per_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [RES_W-1:0] lft_raw, rght_raw, rd_val;

   logic cmplt, cnv, cnv_last;
   logic strt_nxt, upd, clr_prev, set_err;
   logic lft_opn_c, rght_opn_c;
   logic signed [DTRM_W-1:0] dtrm_c;

   assign cmplt = a2d.a2d_cnv_cmplt;
   assign cnv   = (state == CNV_L) || (state == CNV_R);

`ifdef IR_AVG_EN
   logic             second;
   logic [RES_W-1:0] acc;
   logic [SUM_W-1:0] sum;

   assign cnv_last = second;
   assign sum      = SUM_W'(acc) + SUM_W'(a2d.a2d_res);
   assign rd_val   = sum[SUM_W-1:1];

   // Tracks which of the two conversions on the current channel is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         second <= 1'b0;
         acc    <= '0;
      end else if (cnv && cmplt) begin
         second <= ~second;
         if (!second)
            acc <= a2d.a2d_res;
      end else if (!cnv) begin
         second <= 1'b0;
      end
   end
`else
   assign cnv_last = 1'b1;
   assign rd_val   = a2d.a2d_res;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= nxt_state;
   end

   // Next state and per-cycle strobes; a conversion in flight is always allowed to finish.
   always_comb begin
      nxt_state = state;
      strt_nxt  = 1'b0;
      upd       = 1'b0;
      clr_prev  = 1'b0;
      set_err   = 1'b0;
      case (state)
         IDLE: begin
            if (en)
               nxt_state = SETTLE;
         end
         SETTLE: begin
            if (!en) begin
               nxt_state = IDLE;
               clr_prev  = 1'b1;
            end else if (set_cnt == SET_W'(SETTLE_CLKS - 1)) begin
               nxt_state = CNV_L;
               strt_nxt  = 1'b1;
            end
         end
         CNV_L, CNV_R: begin
            if (cmplt) begin
               if (!en) begin
                  nxt_state = IDLE;
                  clr_prev  = 1'b1;
               end else if (!cnv_last) begin
                  strt_nxt  = 1'b1;
               end else if (state == CNV_L) begin
                  nxt_state = CNV_R;
                  strt_nxt  = 1'b1;
               end else begin
                  nxt_state = UPDT;
               end
            end else if (tmo_cnt == TMO_W'(TMO_CLKS - 1)) begin
               nxt_state = IDLE;
               set_err   = 1'b1;
               clr_prev  = 1'b1;
            end
         end
         UPDT: begin
            upd       = 1'b1;
            nxt_state = WAIT;
         end
         WAIT: begin
            if (!en) begin
               nxt_state = IDLE;
               clr_prev  = 1'b1;
            end else if (per_cnt == PER_W'(PERIOD_CLKS - 1)) begin
               nxt_state = SETTLE;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         set_cnt <= '0;
         per_cnt <= '0;
         tmo_cnt <= '0;
      end else begin
         set_cnt <= (state == SETTLE) ? set_cnt + SET_W'(1) : '0;
         if ((nxt_state == SETTLE) && (state != SETTLE))
            per_cnt <= '0;
         else if (state != IDLE)
            per_cnt <= per_cnt + PER_W'(1);
         if (strt_nxt)
            tmo_cnt <= '0;
         else if (cnv)
            tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lft_raw  <= '0;
         rght_raw <= '0;
      end else if (cnv && cmplt && cnv_last) begin
         if (state == CNV_L)
            lft_raw  <= rd_val;
         else
            rght_raw <= rd_val;
      end
   end

   ir_dtrm_calc #(.OPN_THRESH(OPN_THRESH)) u_dtrm (
      .clk        (clk),
      .rst_n      (rst_n),
      .lft        (lft_raw),
      .rght       (rght_raw),
      .upd        (upd),
      .clr        (clr_prev),
      .lft_opn_c  (lft_opn_c),
      .rght_opn_c (rght_opn_c),
      .dtrm_c     (dtrm_c)
   );

   // Registered outputs; the sample set lands together with smpl_vld.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         IR_en        <= 1'b0;
         a2d.a2d_strt <= 1'b0;
         a2d.a2d_chnl <= '0;
         lft_IR       <= '0;
         rght_IR      <= '0;
         lft_opn      <= 1'b0;
         rght_opn     <= 1'b0;
         IR_Dtrm      <= '0;
         smpl_vld     <= 1'b0;
         a2d_err      <= 1'b0;
      end else begin
         IR_en        <= (nxt_state == SETTLE) || (nxt_state == CNV_L) || (nxt_state == CNV_R);
         a2d.a2d_strt <= strt_nxt;
         if (strt_nxt)
            a2d.a2d_chnl <= (nxt_state == CNV_R) ? RGHT_CHNL : LFT_CHNL;
         smpl_vld <= upd;
         if (upd) begin
            lft_IR   <= lft_raw;
            rght_IR  <= rght_raw;
            lft_opn  <= lft_opn_c;
            rght_opn <= rght_opn_c;
            IR_Dtrm  <= dtrm_c;
         end
         if (set_err)
            a2d_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ir_smpl_seq.sv
// Directed self-checking bench for ir_smpl_seq with a behavioural A2D responder.
module tb_ir_smpl_seq;
   import ir_pkg::*;

   localparam int unsigned SETTLE = 16;
   localparam int unsigned PERIOD = 256;
   localparam int unsigned TMO    = 64;
`ifdef IR_AVG_EN
   localparam int unsigned NCNV   = 4;
   localparam int unsigned DT96   = 48;
`else
   localparam int unsigned NCNV   = 2;
   localparam int unsigned DT96   = 96;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic IR_en, lft_opn, rght_opn, smpl_vld, a2d_err;
   logic [11:0] lft_IR, rght_IR;
   logic signed [8:0] IR_Dtrm;

   ir_smpl_seq_if a2d_bus ();

   ir_smpl_seq #(
      .SETTLE_CLKS (SETTLE),
      .PERIOD_CLKS (PERIOD),
      .TMO_CLKS    (TMO),
      .OPN_THRESH  (12'h300)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .a2d      (a2d_bus),
      .IR_en    (IR_en),
      .lft_IR   (lft_IR),
      .rght_IR  (rght_IR),
      .lft_opn  (lft_opn),
      .rght_opn (rght_opn),
      .IR_Dtrm  (IR_Dtrm),
      .smpl_vld (smpl_vld),
      .a2d_err  (a2d_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int t_strt = 0;
   int t_err = 0;
   int n_vld = 0;
   int n0 = 0;
   bit ok;
   bit dbl = 1'b0;
   bit dead = 1'b0;
   logic p_strt = 1'b0;
   logic p_vld = 1'b0;
   logic alt = 1'b0;
   logic [2:0] prev_ch = 3'd7;
   logic [11:0] l_val = 12'h0, r_val = 12'h0, ofs = 12'h0, pend = 12'h0;
   int cd = 0;
   logic [2:0] strt_q[$];

   always @(posedge clk) cyc++;

   // A2D responder (3-clk latency) plus pulse monitor.
   always @(negedge clk) begin
      a2d_bus.a2d_cnv_cmplt = 1'b0;
      if (cd != 0) begin
         cd--;
         if (cd == 0) begin
            a2d_bus.a2d_cnv_cmplt = 1'b1;
            a2d_bus.a2d_res       = pend;
         end
      end
      if (a2d_bus.a2d_strt === 1'b1) begin
         strt_q.push_back(a2d_bus.a2d_chnl);
         t_strt  = cyc;
         alt     = (a2d_bus.a2d_chnl == prev_ch) ? ~alt : 1'b0;
         prev_ch = a2d_bus.a2d_chnl;
         pend    = ((a2d_bus.a2d_chnl == RGHT_CHNL) ? r_val : l_val) + (alt ? ofs : 12'h0);
         if (!dead) cd = 3;
      end
      if (smpl_vld === 1'b1) n_vld++;
      if ((a2d_bus.a2d_strt === 1'b1 && p_strt) || (smpl_vld === 1'b1 && p_vld)) dbl = 1'b1;
      p_strt = (a2d_bus.a2d_strt === 1'b1);
      p_vld  = (smpl_vld === 1'b1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_vld(output bit found);
      found = 1'b0;
      for (int i = 0; i < 2 * PERIOD && !found; i++) begin
         @(negedge clk);
         if (smpl_vld === 1'b1) found = 1'b1;
      end
   endtask

   task automatic sample(input logic [11:0] l, input logic [11:0] r, input string tag);
      l_val = l;
      r_val = r;
      wait_vld(ok);
      chk({tag, "_vld"}, 32'(ok), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ir_en", 32'(IR_en), 32'd0);
      chk("rst_lft_ir", 32'(lft_IR), 32'd0);
      chk("rst_dtrm", {23'd0, IR_Dtrm}, 32'd0);
      chk("rst_vld", 32'(smpl_vld), 32'd0);
      chk("rst_err", 32'(a2d_err), 32'd0);
      chk("rst_strt", 32'(a2d_bus.a2d_strt), 32'd0);

      // First sample: no history, so derivative is zero.
      rst_n = 1'b1;
      strt_q.delete();
      en = 1'b1;
      sample(12'h970, 12'h970, "t1");
      chk("t1_nstrt", 32'(strt_q.size()), NCNV);
      chk("t1_ch_first", 32'((strt_q.size() > 0) ? strt_q[0] : 3'd7), 32'd0);
      chk("t1_ch_last", 32'((strt_q.size() > 0) ? strt_q[strt_q.size()-1] : 3'd7), 32'd4);
      chk("t1_lft", 32'(lft_IR), 32'h970);
      chk("t1_rght", 32'(rght_IR), 32'h970);
      chk("t1_lopn", 32'(lft_opn), 32'd0);
      chk("t1_ropn", 32'(rght_opn), 32'd0);
      chk("t1_dtrm", {23'd0, IR_Dtrm}, 32'd0);
      chk("t1_ir_en", 32'(IR_en), 32'd0);

      sample(12'h9A0, 12'h940, "t2a");
      chk("t2a_dtrm", {23'd0, IR_Dtrm}, DT96);
      sample(12'h000, 12'h900, "t2b");
      chk("t2b_lopn", 32'(lft_opn), 32'd1);
      chk("t2b_ropn", 32'(rght_opn), 32'd0);
      chk("t2b_dtrm", {23'd0, IR_Dtrm}, 32'd0);

      // Threshold boundary and saturation both ways.
      sample(12'h300, 12'hB00, "t3a");
      chk("t3a_lopn", 32'(lft_opn), 32'd0);
      chk("t3a_dtrm", {23'd0, IR_Dtrm}, 32'd0);
      sample(12'hAFF, 12'h300, "t3b");
      chk("t3b_ropn", 32'(rght_opn), 32'd0);
      chk("t3b_dtrm", {23'd0, IR_Dtrm}, 32'h0FF);
      sample(12'h300, 12'hB00, "t3c");
      chk("t3c_dtrm", {23'd0, IR_Dtrm}, 32'h100);

      // en drop during SETTLE.
      en = 1'b0;
      repeat (4) @(negedge clk);
      en = 1'b1;
      repeat (5) @(negedge clk);
      chk("t5_settle_ir_en", 32'(IR_en), 32'd1);
      en = 1'b0;
      @(negedge clk);
      chk("t5_drop_ir_en", 32'(IR_en), 32'd0);

      // en drop during CNV_L.
      repeat (3) @(negedge clk);
      strt_q.delete();
      n0 = n_vld;
      en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < SETTLE + 20 && !ok; i++) begin
         @(negedge clk);
         if (a2d_bus.a2d_strt === 1'b1) ok = 1'b1;
      end
      chk("t5_strt_seen", 32'(ok), 32'd1);
      chk("t5_strt_ch", 32'(a2d_bus.a2d_chnl), 32'd0);
      en = 1'b0;
      repeat (PERIOD) @(negedge clk);
      chk("t5_nstrt", 32'(strt_q.size()), 32'd1);
      chk("t5_no_vld", 32'(n_vld), 32'(n0));
      chk("t5_ir_en", 32'(IR_en), 32'd0);
      chk("t5_err", 32'(a2d_err), 32'd0);

      // Converter never answers.
      dead = 1'b1;
      n0 = n_vld;
      en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < SETTLE + TMO + 20 && !ok; i++) begin
         @(negedge clk);
         if (a2d_err === 1'b1) begin
            ok = 1'b1;
            t_err = cyc;
         end
      end
      chk("t4_err_seen", 32'(ok), 32'd1);
      chk("t4_err_lat", 32'(t_err - t_strt), TMO);
      chk("t4_state", {29'd0, dut.state}, {29'd0, IDLE});
      chk("t4_ir_en", 32'(IR_en), 32'd0);
      en = 1'b0;
      repeat (10) @(negedge clk);
      chk("t4_no_vld", 32'(n_vld), 32'(n0));
      chk("t4_err_sticky", 32'(a2d_err), 32'd1);
      dead = 1'b0;

      // Asynchronous reset during CNV_R.
      l_val = 12'h9A0;
      r_val = 12'h940;
      en = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < SETTLE + 40 && !ok; i++) begin
         @(negedge clk);
         if (a2d_bus.a2d_strt === 1'b1 && a2d_bus.a2d_chnl == RGHT_CHNL) ok = 1'b1;
      end
      chk("t6_cnvr_seen", 32'(ok), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_ir_en", 32'(IR_en), 32'd0);
      chk("t6_lft", 32'(lft_IR), 32'd0);
      chk("t6_rght", 32'(rght_IR), 32'd0);
      chk("t6_dtrm", {23'd0, IR_Dtrm}, 32'd0);
      chk("t6_err", 32'(a2d_err), 32'd0);
      chk("t6_chnl", 32'(a2d_bus.a2d_chnl), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sample(12'h9A0, 12'h940, "t6r");
      chk("t6r_lft", 32'(lft_IR), 32'h9A0);
      chk("t6r_dtrm", {23'd0, IR_Dtrm}, 32'd0);

`ifdef IR_AVG_EN
      ofs = 12'h002;
      sample(12'h900, 12'h940, "avg");
      chk("avg_lft", 32'(lft_IR), 32'h901);
`endif

      en = 1'b0;
      repeat (5) @(negedge clk);
      chk("no_dbl_pulse", 32'(dbl), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
